ram_stream_sequencer: RTL and testbench

//  - Owns the single shared RAM port and moves one block per accelerator channel (FFT, FIR).
//  - Channel flow: RAM -> channel input FIFO, then channel output FIFO -> RAM.
//  - Sits in top_level between the RAM interface (addr, read/write enables) and the
//    to_*/from_* FIFOs.
//  - Time-shares the RAM port with a 4-slot round-robin over {fft_rd, fft_wr, fir_rd, fir_wr}.

---
 rtl/ram_stream_sequencer_if.sv | 46 ++++
 rtl/ram_stream_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_ram_stream_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_stream_sequencer_if.sv
// Purpose: bundles the sequencer's control, RAM-port and FIFO-port signals.
// Latency: none, wiring only.
// Backpressure: FIFO full/empty flags travel here towards the sequencer.
interface ram_stream_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] addr;
    logic              ram_read_enable;
    logic              ram_write_enable;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              to_fft_full;
    logic              fft_put;
    logic [DATA_W-1:0] fft_in_data;
    logic              from_fft_empty;
    logic              fft_get;
    logic [DATA_W-1:0] fft_out_data;
    logic              to_fir_full;
    logic              fir_put;
    logic [DATA_W-1:0] fir_in_data;
    logic              from_fir_empty;
    logic              fir_get;
    logic [DATA_W-1:0] fir_out_data;

    modport master (
        input  start, ram_rdata,
        input  to_fft_full, from_fft_empty, fft_out_data,
        input  to_fir_full, from_fir_empty, fir_out_data,
        output busy, done, addr, ram_read_enable, ram_write_enable, ram_wdata,
        output fft_put, fft_in_data, fft_get,
        output fir_put, fir_in_data, fir_get
    );

    modport slave (
        output start, ram_rdata,
        output to_fft_full, from_fft_empty, fft_out_data,
        output to_fir_full, from_fir_empty, fir_out_data,
        input  busy, done, addr, ram_read_enable, ram_write_enable, ram_wdata,
        input  fft_put, fft_in_data, fft_get,
        input  fir_put, fir_in_data, fir_get
    );
endinterface

// File: rtl/ram_stream_sequencer.sv
// Purpose: shares one RAM port between FFT/FIR block transfers (RAM->in FIFO, out FIFO->RAM); ARB_FFT_PRIORITY_EN selects fixed FFT priority.
// Latency: a read transfer costs 3 cycles (ARB, READ, LOAD), a write transfer 2 cycles (ARB, WRITE).
// Backpressure: a slot is skipped while its input FIFO is full or its output FIFO is empty; arbitration waits in ARB.
module ram_stream_sequencer #(
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 32,
    parameter int                BLOCK_LEN    = 256,
    parameter logic [ADDR_W-1:0] FFT_SRC_BASE = 'h0000,
    parameter logic [ADDR_W-1:0] FFT_DST_BASE = 'h1000,
    parameter logic [ADDR_W-1:0] FIR_SRC_BASE = 'h2000,
    parameter logic [ADDR_W-1:0] FIR_DST_BASE = 'h3000
) (
    input  logic                   clk,
    input  logic                   reset,
    ram_stream_sequencer_if.master bus
);
    localparam int CNT_W = $clog2(BLOCK_LEN) + 1;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t LEN = cnt_t'(BLOCK_LEN);

    // Slot encoding: bit1 selects the channel (0 FFT, 1 FIR), bit0 selects write.
    localparam logic [1:0] S_FFT_RD = 2'd0;
    localparam logic [1:0] S_FFT_WR = 2'd1;
    localparam logic [1:0] S_FIR_RD = 2'd2;
    localparam logic [1:0] S_FIR_WR = 2'd3;

    typedef enum logic [2:0] {IDLE, ARB, READ, LOAD, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [1:0]        grant_q, grant_d;
    cnt_t              cnt_q [4];
    cnt_t              cnt_d [4];
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_en_q, rd_en_d;
    logic              wr_en_q, wr_en_d;
    logic [1:0]        put_q, put_d;
    logic [1:0]        get_q, get_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [3:0]        elig;
    logic              all_done;
    logic              found;
    logic [1:0]        pick;

    // Per-slot eligibility and block completion.
    always_comb begin
        elig[S_FFT_RD] = (cnt_q[S_FFT_RD] < LEN) && !bus.to_fft_full;
        elig[S_FFT_WR] = (cnt_q[S_FFT_WR] < LEN) && !bus.from_fft_empty;
        elig[S_FIR_RD] = (cnt_q[S_FIR_RD] < LEN) && !bus.to_fir_full;
        elig[S_FIR_WR] = (cnt_q[S_FIR_WR] < LEN) && !bus.from_fir_empty;
        all_done = (cnt_q[0] == LEN) && (cnt_q[1] == LEN) &&
                   (cnt_q[2] == LEN) && (cnt_q[3] == LEN);
    end

`ifdef ARB_FFT_PRIORITY_EN
    // Fixed priority: FFT drains before it refills, FIR only when FFT has nothing to do.
    always_comb begin
        found = 1'b1;
        pick  = S_FFT_WR;
        if (elig[S_FFT_WR])      pick = S_FFT_WR;
        else if (elig[S_FFT_RD]) pick = S_FFT_RD;
        else if (elig[S_FIR_WR]) pick = S_FIR_WR;
        else if (elig[S_FIR_RD]) pick = S_FIR_RD;
        else                     found = 1'b0;
    end
`else
    // Round-robin: search starts at the slot after the last grant.
    always_comb begin
        logic [1:0] idx;
        found = 1'b0;
        pick  = rr_ptr_q;
        idx   = rr_ptr_q;
        for (int i = 0; i < 4; i++) begin
            idx = rr_ptr_q + 2'(i);
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end
`endif

    // Next state plus next values of all registered outputs.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_en_d  = 1'b0;
        wr_en_d  = 1'b0;
        put_d    = 2'b00;
        get_d    = 2'b00;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ARB;
                    for (int i = 0; i < 4; i++) cnt_d[i] = '0;
                end
            end
            ARB: begin
                if (all_done) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (found) begin
`ifndef ARB_FFT_PRIORITY_EN
                    rr_ptr_d = pick + 2'd1;
`endif
                    grant_d = pick;
                    if (!pick[0]) begin
                        state_d = READ;
                        rd_en_d = 1'b1;
                        addr_d  = (pick[1] ? FIR_SRC_BASE : FFT_SRC_BASE) +
                                  ADDR_W'(cnt_q[pick]);
                    end else begin
                        state_d        = WRITE;
                        wr_en_d        = 1'b1;
                        get_d[pick[1]] = 1'b1;
                        addr_d         = (pick[1] ? FIR_DST_BASE : FFT_DST_BASE) +
                                         ADDR_W'(cnt_q[pick]);
                        wdata_d        = pick[1] ? bus.fir_out_data : bus.fft_out_data;
                    end
                end
            end
            READ: begin
                state_d           = LOAD;
                put_d[grant_q[1]] = 1'b1;
            end
            LOAD, WRITE: begin
                state_d = ARB;
                if (cnt_q[grant_q] < LEN) cnt_d[grant_q] = cnt_q[grant_q] + cnt_t'(1);
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, counters and registered strobes; reset clears everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            put_q    <= '0;
            get_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_en_q  <= rd_en_d;
            wr_en_q  <= wr_en_d;
            put_q    <= put_d;
            get_q    <= get_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // RAM read data arrives in LOAD and is forwarded straight into the granted input FIFO.
    assign bus.fft_in_data = (state_q == LOAD && grant_q == S_FFT_RD) ? bus.ram_rdata : '0;
    assign bus.fir_in_data = (state_q == LOAD && grant_q == S_FIR_RD) ? bus.ram_rdata : '0;

    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.addr             = addr_q;
    assign bus.ram_read_enable  = rd_en_q;
    assign bus.ram_write_enable = wr_en_q;
    assign bus.ram_wdata        = wdata_q;
    assign bus.fft_put          = put_q[0];
    assign bus.fir_put          = put_q[1];
    assign bus.fft_get          = get_q[0];
    assign bus.fir_get          = get_q[1];
endmodule

// File: tb/tb_ram_stream_sequencer.sv
// Purpose: directed bench for ram_stream_sequencer with a RAM model, loopback FIFOs and a scoreboard.
// Latency: expected RAM operations are queued in order and checked as they appear on the bus.
// Backpressure: FFT input-full can be held to stall the FFT read slot.
module tb_ram_stream_sequencer;
    localparam int LEN = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ram_stream_sequencer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ram_stream_sequencer #(.ADDR_W(32), .DATA_W(32), .BLOCK_LEN(LEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    ev_t         exp_q[$];
    logic [31:0] fft_q[$];
    logic [31:0] fir_q[$];
    logic        fft_full_hold = 1'b0;
    logic [31:0] last_rd_addr = '0;

    function automatic logic [31:0] ram_f(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] src_base(input int ch);
        return (ch == 0) ? 32'h0000 : 32'h2000;
    endfunction

    function automatic logic [31:0] dst_base(input int ch);
        return (ch == 0) ? 32'h1000 : 32'h3000;
    endfunction

    function automatic void push_rd(input int ch, input int i);
        ev_t e;
        e.is_wr = 1'b0;
        e.addr  = src_base(ch) + 32'(i);
        e.data  = '0;
        exp_q.push_back(e);
    endfunction

    function automatic void push_wr(input int ch, input int i);
        ev_t e;
        e.is_wr = 1'b1;
        e.addr  = dst_base(ch) + 32'(i);
        e.data  = ram_f(src_base(ch) + 32'(i));
        exp_q.push_back(e);
    endfunction

    // Order of RAM operations for one block with all FIFOs free and loopback feeding the outputs.
    function automatic void push_full_block();
`ifdef ARB_FFT_PRIORITY_EN
        for (int ch = 0; ch < 2; ch++)
            for (int i = 0; i < LEN; i++) begin
                push_rd(ch, i);
                push_wr(ch, i);
            end
`else
        for (int i = 0; i < LEN; i++) begin
            push_rd(0, i);
            push_wr(0, i);
            push_rd(1, i);
            push_wr(1, i);
        end
`endif
    endfunction

    // RAM model: registered read data, one cycle after the read strobe.
    always @(posedge clk or posedge reset) begin
        if (reset) bus.ram_rdata <= '0;
        else if (bus.ram_read_enable) bus.ram_rdata <= ram_f(bus.addr);
    end

    // Loopback FIFOs: each input FIFO feeds its own output FIFO directly.
    always @(negedge clk) begin
        if (reset) begin
            fft_q.delete();
            fir_q.delete();
        end else begin
            if (bus.fft_put) fft_q.push_back(bus.fft_in_data);
            if (bus.fir_put) fir_q.push_back(bus.fir_in_data);
            if (bus.fft_get && fft_q.size() > 0) void'(fft_q.pop_front());
            if (bus.fir_get && fir_q.size() > 0) void'(fir_q.pop_front());
        end
        bus.from_fft_empty = (fft_q.size() == 0);
        bus.from_fir_empty = (fir_q.size() == 0);
        bus.fft_out_data   = (fft_q.size() > 0) ? fft_q[0] : '0;
        bus.fir_out_data   = (fir_q.size() > 0) ? fir_q[0] : '0;
        bus.to_fft_full    = fft_full_hold;
        bus.to_fir_full    = 1'b0;
    end

    // Monitor: pops the scoreboard whenever the DUT strobes the RAM or a FIFO.
    always @(negedge clk) begin
        if (!reset) begin
            chk("rd_wr_exclusive", 32'(bus.ram_read_enable & bus.ram_write_enable), 32'd0);
            chk("single_fifo_op", 32'(32'(bus.fft_put) + 32'(bus.fir_put) +
                                      32'(bus.fft_get) + 32'(bus.fir_get) > 1), 32'd0);
            if (bus.ram_read_enable || bus.ram_write_enable) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ram_op: addr %h wr %0d, expected no operation",
                             bus.addr, bus.ram_write_enable);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("op_kind", 32'(bus.ram_write_enable), 32'(e.is_wr));
                    chk("op_addr", bus.addr, e.addr);
                    if (e.is_wr) begin
                        chk("wdata", bus.ram_wdata, e.data);
                        chk("get_chan", {30'd0, bus.fir_get, bus.fft_get},
                            (e.addr >= 32'h3000) ? 32'd2 : 32'd1);
                    end
                end
                if (bus.ram_read_enable) last_rd_addr = bus.addr;
            end
            if (bus.fft_put || bus.fir_put) begin
                chk("put_chan", {30'd0, bus.fir_put, bus.fft_put},
                    (last_rd_addr >= 32'h2000) ? 32'd2 : 32'd1);
                chk("put_data", bus.fft_put ? bus.fft_in_data : bus.fir_in_data,
                    ram_f(last_rd_addr));
            end
            if (bus.done) done_cnt++;
        end
    end

    task automatic check_idle_outputs(input string name);
        chk({name, "_busy"}, 32'(bus.busy), 32'd0);
        chk({name, "_done"}, 32'(bus.done), 32'd0);
        chk({name, "_strobes"}, {26'd0, bus.ram_read_enable, bus.ram_write_enable,
                                 bus.fft_put, bus.fir_put, bus.fft_get, bus.fir_get}, 32'd0);
        chk({name, "_addr"}, bus.addr, 32'd0);
        chk({name, "_wdata"}, bus.ram_wdata, 32'd0);
        chk({name, "_in_data"}, bus.fft_in_data | bus.fir_in_data, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic pulse_start(input string name);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk({name, "_busy_after_start"}, 32'(bus.busy), 32'd1);
    endtask

    task automatic wait_done(input string name, input int base_done);
        int n;
        n = 0;
        while (!bus.done && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_done_seen"}, 32'(bus.done), 32'd1);
        @(posedge clk);
        #1;
        chk({name, "_busy_cleared"}, 32'(bus.busy), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk({name, "_all_ops_seen"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_one_done"}, 32'(done_cnt - base_done), 32'd1);
    endtask

    initial begin
        int base;
        int n;
        bus.start = 1'b0;

        // Reset values.
        do_reset();
        check_idle_outputs("reset");

        // Abort in the middle of a write.
        push_full_block();
        pulse_start("abort");
        n = 0;
        while (!bus.ram_write_enable && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("abort_write_reached", 32'(bus.ram_write_enable), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_strobes_low", {29'd0, bus.ram_write_enable, bus.fft_get | bus.fir_get,
                                  bus.ram_read_enable}, 32'd0);
        chk("abort_busy_low", 32'(bus.busy), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle_outputs("after_abort");

        // Full block straight after the abort: counters must start again from zero.
        base = done_cnt;
        push_full_block();
        pulse_start("block");
        wait_done("block", base);

        // FFT input held full: FIR completes alone, FFT resumes at word 0.
        do_reset();
        fft_full_hold = 1'b1;
        for (int i = 0; i < LEN; i++) begin
            push_rd(1, i);
            push_wr(1, i);
        end
        for (int i = 0; i < LEN; i++) begin
            push_rd(0, i);
            push_wr(0, i);
        end
        base = done_cnt;
        pulse_start("stall");
        n = 0;
        while (exp_q.size() > 2 * LEN && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (10) @(posedge clk);
        #1;
        chk("stall_fft_untouched", 32'(exp_q.size()), 32'(2 * LEN));
        chk("stall_still_busy", 32'(bus.busy), 32'd1);
        fft_full_hold = 1'b0;
        wait_done("stall", base);

        // A second start while busy is ignored.
        do_reset();
        push_full_block();
        base = done_cnt;
        pulse_start("restart");
        repeat (8) @(posedge clk);
        #1;
        chk("restart_busy_before", 32'(bus.busy), 32'd1);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done("restart", base);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
